tiamc1_dl_ctrl: RTL and testbench
=================================

# tiamc1_dl_ctrl

Download and boot sequencer for the TIA-MC1 core. It sits between the HPS ioctl download stream and the core's ROM storage. It steers index-0 bytes into per-region ROM write ports and captures the index-1 title number. It holds the core in reset until a complete image has loaded, then hands the shared ROM address port to the CPU.

## Interface
Parameters:
- `HOLD_CYCLES`, 1024: core-reset stretch after download end; min 1.
- `NREG`, 4: number of ROM regions; must match the package region table.

Ports (one clock; reset is asynchronous and active-low):
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `dn_download`  in  1  ioctl download active.
- `dn_index`  in  8  ioctl index.
- `dn_addr`  in  20  ioctl byte address.
- `dn_data`  in  8  ioctl byte.
- `dn_wr`  in  1  ioctl write strobe, one cycle per byte.
- `cpu_addr`  in  16  CPU ROM address.
- `mem_addr`  out  16  region-local ROM address.
- `mem_din`  out  8  ROM write data.
- `mem_we`  out  NREG  one-hot region write enable.
- `core_reset`  out  1  active-high reset to the core.
- `rom_ready`  out  1  a complete image has been loaded since reset.
- `dn_err`  out  1  sticky; last download was short or wrote out of map.
- `tno`  out  8  title number.

## Operation
- Region map, from the package; local offset = `dn_addr` − base:
  - R0 `0x00000–0x0FFFF`
  - R1 `0x10000–0x17FFF`
  - R2 `0x18000–0x1FFFF`
  - R3 `0x20000–0x200FF`
  - `ROM_TOTAL` = `0x20100`.
- States: `IDLE`, `LOAD`, `HOLD`, `RUN`. The reset state is `IDLE`.
- `IDLE`:
  - Goes to `LOAD` when `dn_download`=1 and `dn_index`=0.
  - Otherwise waits; no auto-boot without ROM.
- `LOAD`:
  - Each `dn_wr` with index 0 that decodes to region k asserts `mem_we[k]`.
  - An index-0 write with `dn_addr` ≥ `ROM_TOTAL` asserts nothing, sets `dn_err`, and is not counted.
  - Count in-map bytes in a 20-bit saturating counter, which clears on `LOAD` entry.
  - On `dn_download` falling: if count ≥ `ROM_TOTAL`, set `rom_ready`=1 and clear `dn_err` unless an out-of-map write occurred this load; else set `dn_err`=1 and `rom_ready`=0. Then go to `HOLD`, loading the hold counter with `HOLD_CYCLES`.
- `HOLD`:
  - Decrement each cycle.
  - At 0, go to `RUN` if `rom_ready`, else `IDLE`.
  - `dn_download` rising with index 0 goes to `LOAD` immediately; the counter is discarded.
- `RUN`:
  - `mem_addr` = `cpu_addr`, passed combinationally; `mem_we`=0.
  - A new index-0 download goes to `LOAD`. That transition does not clear `rom_ready` until the falling-edge check.
- Index 1, any state:
  - `dn_wr` with `dn_addr`=0 latches `tno` <= `dn_data`.
  - Other addresses are ignored.
  - Writes never assert `mem_we`.
- Other indices are ignored entirely.
- `core_reset` = 1 in `IDLE`, `LOAD` and `HOLD`; 0 only in `RUN`.

## Timing
- Reset (`reset_n`=0, async) sets:
  - state `IDLE`
  - `core_reset`=1, `rom_ready`=0, `dn_err`=0, `tno`=0
  - `mem_we`=0, `mem_addr`=0, `mem_din`=0
- Write pipeline:
  - `dn_wr` at cycle t registers `mem_we`, `mem_addr` and `mem_din` at t+1, for exactly one cycle.
  - Back-to-back strobes are supported, one byte per cycle.
- `dn_download` rising, with a `dn_wr` in the same cycle: the write is accepted.
- `dn_download` falling, with a `dn_wr` in the same cycle: the write is accepted and counted before the completeness check.
- `core_reset` deasserts exactly `HOLD_CYCLES`+1 cycles after the registered falling edge of `dn_download`.
- `reset_n` mid-`LOAD`: immediate return to `IDLE`; the partial image is not `rom_ready`.

## Structure
- Package `tiamc1_dl_pkg` holds:
  - state enum
  - region base/size arrays
  - `ROM_TOTAL`
  - index constants `IDX_ROM`=0, `IDX_TNO`=1
- Sub-module `tiamc1_dl_region_dec`: combinational. Maps `dn_addr` to {hit, one-hot region, 16-bit offset}.

## Test plan
- Full download of `0x20100` bytes, `HOLD_CYCLES`=16:
  - writes to `0x00000`, `0x10000`, `0x20000` pulse `mem_we` = `0001`, `0010`, `1000` with offset 0.
  - `rom_ready`=1; `core_reset` falls 17 cycles after `dn_download` falls.
- Short download of `0x100` bytes: `dn_err`=1, `rom_ready`=0, returns to `IDLE`, `core_reset` stays 1.
- Index-1 write `0x03` at addr 0, then `0x55` at addr 1: `tno`=`0x03`, no `mem_we` activity.
- Write to `0x20100` during `LOAD`: no `mem_we`, `dn_err`=1, count unchanged.
- `reset_n` pulsed low mid-`LOAD`: all outputs at reset values asynchronously; a fresh full download boots normally.
- Re-download from `RUN`: `core_reset` rises the cycle after `dn_download`; CPU address path is masked; successful reload returns to `RUN`.

Source files
------------

// File: rtl/tiamc1_dl_pkg.sv
// tiamc1_dl_pkg
// Shared definitions for the TIA-MC1 download/boot sequencer:
//   - sequencer state encoding
//   - ROM region map (base / size per region) and total image size
//   - ioctl index constants
//   - small helpers for region limits and the saturating byte counter
package tiamc1_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } dl_state_t;

  localparam int NREG_MAP = 4;

  // Regions are contiguous from address 0, so anything at or above
  // ROM_TOTAL misses every region.
  localparam logic [19:0] REG_BASE [NREG_MAP] = '{20'h00000, 20'h10000, 20'h18000, 20'h20000};
  localparam logic [19:0] REG_SIZE [NREG_MAP] = '{20'h10000, 20'h08000, 20'h08000, 20'h00100};

  localparam logic [19:0] ROM_TOTAL = 20'h20100;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_TNO = 8'd1;

  // First address past region k.
  function automatic logic [19:0] reg_limit(input int k);
    return REG_BASE[k] + REG_SIZE[k];
  endfunction

  // Byte counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    if (v == 20'hFFFFF) begin
      return v;
    end else begin
      return v + 20'h00001;
    end
  endfunction

endpackage

// File: rtl/tiamc1_dl_region_dec.sv
// tiamc1_dl_region_dec
// Combinational decode of an ioctl byte address into the ROM region map.
// Ports:
//   addr    in  20     ioctl byte address
//   hit     out 1      address falls inside some region
//   sel     out NREG   one-hot region select (all zero on a miss)
//   offset  out 16     address relative to the selected region base
module tiamc1_dl_region_dec
  import tiamc1_dl_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic [19:0]     addr,
  output logic            hit,
  output logic [NREG-1:0] sel,
  output logic [15:0]     offset
);

  logic [19:0] diff;

  // Range-compare every region; regions never overlap, so OR-ing the
  // masked offsets yields the offset of the single selected region.
  always_comb begin
    sel    = '0;
    offset = 16'h0000;
    diff   = 20'h00000;
    for (int k = 0; k < NREG; k++) begin
      sel[k] = (addr >= REG_BASE[k]) && (addr < reg_limit(k));
      diff   = addr - REG_BASE[k];
      offset = offset | (sel[k] ? diff[15:0] : 16'h0000);
    end
    hit = |sel;
  end

endmodule

// File: rtl/tiamc1_dl_ctrl.sv
// tiamc1_dl_ctrl
// Download and boot sequencer: steers index-0 ioctl bytes into per-region
// ROM write ports, latches the index-1 title number, holds the core in
// reset until a complete image is loaded, then gives the ROM address port
// to the CPU.
// Ports:
//   clk_sys, reset_n      clock, async active-low reset
//   dn_download/index/addr/data/wr   ioctl download stream
//   cpu_addr              CPU ROM address (used in RUN)
//   mem_addr/mem_din/mem_we          ROM write port (one-hot region enable)
//   core_reset            active-high core reset, low only in RUN
//   rom_ready             complete image loaded since reset
//   dn_err                sticky short / out-of-map download flag
//   tno                   title number
module tiamc1_dl_ctrl
  import tiamc1_dl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int          NREG        = 4
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            dn_download,
  input  logic [7:0]      dn_index,
  input  logic [19:0]     dn_addr,
  input  logic [7:0]      dn_data,
  input  logic            dn_wr,
  input  logic [15:0]     cpu_addr,
  output logic [15:0]     mem_addr,
  output logic [7:0]      mem_din,
  output logic [NREG-1:0] mem_we,
  output logic            core_reset,
  output logic            rom_ready,
  output logic            dn_err,
  output logic [7:0]      tno
);

  dl_state_t       state_r, state_nx;
  logic [31:0]     hold_r;
  logic [19:0]     cnt_r, cnt_base, cnt_nx;
  logic            oom_r, oom_nx;
  logic            rom_ready_r, dn_err_r, core_reset_r;
  logic [7:0]      tno_r, din_r;
  logic [15:0]     wr_addr_r;
  logic [NREG-1:0] we_r;

  logic            dec_hit;
  logic [NREG-1:0] dec_sel;
  logic [15:0]     dec_off;

  logic go_load, rom_wr, in_wr, oom_wr, fall;

  tiamc1_dl_region_dec #(.NREG(NREG)) u_dec (
    .addr   (dn_addr),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .offset (dec_off)
  );

  // Write qualification and next byte count. A write in the cycle that
  // starts a load is accepted and counted from a freshly cleared counter.
  always_comb begin
    go_load  = dn_download && (dn_index == IDX_ROM);
    rom_wr   = dn_wr && (dn_index == IDX_ROM) && ((state_r == ST_LOAD) || go_load);
    in_wr    = rom_wr && dec_hit;
    oom_wr   = rom_wr && !dec_hit;
    fall     = (state_r == ST_LOAD) && !dn_download;
    cnt_base = (state_r == ST_LOAD) ? cnt_r : 20'h00000;
    cnt_nx   = in_wr ? sat_inc(cnt_base) : cnt_base;
    oom_nx   = ((state_r == ST_LOAD) ? oom_r : 1'b0) | oom_wr;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_load) state_nx = ST_LOAD;
        else         state_nx = ST_IDLE;
      end
      ST_LOAD: begin
        if (!dn_download) state_nx = ST_HOLD;
        else              state_nx = ST_LOAD;
      end
      ST_HOLD: begin
        if (go_load)               state_nx = ST_LOAD;
        else if (hold_r == 32'd0)  state_nx = rom_ready_r ? ST_RUN : ST_IDLE;
        else                       state_nx = ST_HOLD;
      end
      ST_RUN: begin
        if (go_load) state_nx = ST_LOAD;
        else         state_nx = ST_RUN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register, byte counter, out-of-map tracker and hold timer.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 20'h00000;
      oom_r   <= 1'b0;
      hold_r  <= 32'd0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      oom_r   <= oom_nx;
      if (fall) begin
        hold_r <= 32'(HOLD_CYCLES);
      end else if ((state_r == ST_HOLD) && (hold_r != 32'd0)) begin
        hold_r <= hold_r - 32'd1;
      end
    end
  end

  // Image status flags and core reset. The completeness check sees the
  // byte written in the same cycle as the download falling edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_ready_r  <= 1'b0;
      dn_err_r     <= 1'b0;
      core_reset_r <= 1'b1;
    end else begin
      if (fall) begin
        if (cnt_nx >= ROM_TOTAL) begin
          rom_ready_r <= 1'b1;
          dn_err_r    <= oom_nx;
        end else begin
          rom_ready_r <= 1'b0;
          dn_err_r    <= 1'b1;
        end
      end else if (oom_wr) begin
        dn_err_r <= 1'b1;
      end
      core_reset_r <= (state_nx != ST_RUN);
    end
  end

  // ROM write pipeline (one registered pulse per accepted byte) and
  // title-number latch.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      we_r      <= '0;
      wr_addr_r <= 16'h0000;
      din_r     <= 8'h00;
      tno_r     <= 8'h00;
    end else begin
      we_r <= in_wr ? dec_sel : '0;
      if (in_wr) begin
        wr_addr_r <= dec_off;
        din_r     <= dn_data;
      end
      if (dn_wr && (dn_index == IDX_TNO) && (dn_addr == 20'h00000)) begin
        tno_r <= dn_data;
      end
    end
  end

  // The CPU owns the shared address port only while the core runs.
  assign mem_addr   = (state_r == ST_RUN) ? cpu_addr : wr_addr_r;
  assign mem_din    = din_r;
  assign mem_we     = we_r;
  assign core_reset = core_reset_r;
  assign rom_ready  = rom_ready_r;
  assign dn_err     = dn_err_r;
  assign tno        = tno_r;

endmodule

// File: tb/tb_tiamc1_dl_ctrl.sv
// tb_tiamc1_dl_ctrl
// Directed self-checking bench for tiamc1_dl_ctrl with HOLD_CYCLES = 16.
module tb_tiamc1_dl_ctrl;

  logic        clk_sys;
  logic        reset_n;
  logic        dn_download;
  logic [7:0]  dn_index;
  logic [19:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [15:0] cpu_addr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [3:0]  mem_we;
  logic        core_reset;
  logic        rom_ready;
  logic        dn_err;
  logic [7:0]  tno;

  int checks = 0;
  int errors = 0;

  tiamc1_dl_ctrl #(.HOLD_CYCLES(16), .NREG(4)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .dn_download (dn_download),
    .dn_index    (dn_index),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_wr       (dn_wr),
    .cpu_addr    (cpu_addr),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .core_reset  (core_reset),
    .rom_ready   (rom_ready),
    .dn_err      (dn_err),
    .tno         (tno)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dd(input int a);
    return 8'(a + (a >> 12) + 17);
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Full image: one byte per cycle, 0x00000..0x200FF, last byte written in
  // the same cycle dn_download drops. Optionally slips one out-of-map
  // write in after 0x20000. Then times the core reset release.
  task automatic full_load(input string nm, input logic with_oom, input logic exp_rdy0);
    int zero_at;
    for (int a = 0; a < 'h20100; a++) begin
      dn_download = (a != 'h200FF);
      dn_index    = 8'd0;
      dn_addr     = 20'(a);
      dn_data     = dd(a);
      dn_wr       = 1'b1;
      step();
      if (a == 0) begin
        chk({nm, "_we_r0"}, 32'(mem_we), 32'h1);
        chk({nm, "_addr_r0"}, 32'(mem_addr), 32'h0);
        chk({nm, "_din_r0"}, 32'(mem_din), 32'(dd(0)));
        chk({nm, "_corerst_load"}, 32'(core_reset), 32'h1);
        chk({nm, "_rdy_kept"}, 32'(rom_ready), 32'(exp_rdy0));
      end
      if (a == 'h10000) begin
        chk({nm, "_we_r1"}, 32'(mem_we), 32'h2);
        chk({nm, "_addr_r1"}, 32'(mem_addr), 32'h0);
      end
      if (a == 'h18000) begin
        chk({nm, "_we_r2"}, 32'(mem_we), 32'h4);
        chk({nm, "_addr_r2"}, 32'(mem_addr), 32'h0);
      end
      if (a == 'h20000) begin
        chk({nm, "_we_r3"}, 32'(mem_we), 32'h8);
        chk({nm, "_addr_r3"}, 32'(mem_addr), 32'h0);
        chk({nm, "_din_r3"}, 32'(mem_din), 32'(dd('h20000)));
        if (with_oom) begin
          dn_addr = 20'h20100;
          dn_data = 8'hA5;
          step();
          chk({nm, "_oom_we"}, 32'(mem_we), 32'h0);
          chk({nm, "_oom_err"}, 32'(dn_err), 32'h1);
          chk({nm, "_oom_din"}, 32'(mem_din), 32'(dd('h20000)));
        end
      end
    end
    dn_wr = 1'b0;
    chk({nm, "_we_last"}, 32'(mem_we), 32'h8);
    chk({nm, "_addr_last"}, 32'(mem_addr), 32'h00FF);
    chk({nm, "_rdy"}, 32'(rom_ready), 32'h1);
    chk({nm, "_err"}, 32'(dn_err), 32'(with_oom));
    chk({nm, "_corerst_fall"}, 32'(core_reset), 32'h1);
    zero_at = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (core_reset == 1'b0 && zero_at == 0) zero_at = n;
    end
    chk({nm, "_corerst_release_cycle"}, 32'(zero_at), 32'd17);
  endtask

  initial begin
    int zeros;
    reset_n     = 1'b0;
    dn_download = 1'b0;
    dn_index    = 8'd0;
    dn_addr     = 20'h00000;
    dn_data     = 8'h00;
    dn_wr       = 1'b0;
    cpu_addr    = 16'hBEEF;

    // Reset state
    repeat (3) step();
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_din", 32'(mem_din), 32'h0);
    chk("rst_corerst", 32'(core_reset), 32'h1);
    chk("rst_rdy", 32'(rom_ready), 32'h0);
    chk("rst_err", 32'(dn_err), 32'h0);
    chk("rst_tno", 32'(tno), 32'h0);
    reset_n = 1'b1;
    step();
    chk("idle_no_autoboot", 32'(core_reset), 32'h1);

    // Index 1: only address 0 sets the title number
    dn_download = 1'b1; dn_index = 8'd1; dn_addr = 20'h00000; dn_data = 8'h03; dn_wr = 1'b1;
    step();
    chk("tno_a0", 32'(tno), 32'h03);
    chk("tno_a0_we", 32'(mem_we), 32'h0);
    dn_addr = 20'h00001; dn_data = 8'h55;
    step();
    chk("tno_a1", 32'(tno), 32'h03);
    chk("tno_a1_we", 32'(mem_we), 32'h0);
    dn_wr = 1'b0; dn_download = 1'b0;
    step();
    chk("tno_end_we", 32'(mem_we), 32'h0);
    chk("tno_end_corerst", 32'(core_reset), 32'h1);

    // Short download of 0x100 bytes
    for (int a = 0; a < 'h100; a++) begin
      dn_download = (a != 'hFF); dn_index = 8'd0; dn_addr = 20'(a); dn_data = dd(a); dn_wr = 1'b1;
      step();
    end
    dn_wr = 1'b0;
    chk("short_we", 32'(mem_we), 32'h1);
    chk("short_addr", 32'(mem_addr), 32'h00FF);
    chk("short_err", 32'(dn_err), 32'h1);
    chk("short_rdy", 32'(rom_ready), 32'h0);
    zeros = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (core_reset == 1'b0) zeros++;
    end
    chk("short_corerst_low_cycles", 32'(zeros), 32'd0);
    chk("short_rdy_after", 32'(rom_ready), 32'h0);

    // Async reset in the middle of a load
    for (int a = 0; a < 5; a++) begin
      dn_download = 1'b1; dn_index = 8'd0; dn_addr = 20'(a); dn_data = dd(a); dn_wr = 1'b1;
      step();
    end
    chk("mid_we", 32'(mem_we), 32'h1);
    chk("mid_addr", 32'(mem_addr), 32'h0004);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_we", 32'(mem_we), 32'h0);
    chk("arst_addr", 32'(mem_addr), 32'h0);
    chk("arst_din", 32'(mem_din), 32'h0);
    chk("arst_err", 32'(dn_err), 32'h0);
    chk("arst_tno", 32'(tno), 32'h0);
    chk("arst_rdy", 32'(rom_ready), 32'h0);
    chk("arst_corerst", 32'(core_reset), 32'h1);
    dn_download = 1'b0; dn_wr = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    step();

    // Fresh full download with an out-of-map write mixed in
    full_load("full", 1'b1, 1'b0);
    chk("run_mem_addr", 32'(mem_addr), 32'hBEEF);
    chk("run_we", 32'(mem_we), 32'h0);
    cpu_addr = 16'h1234;
    #1;
    chk("run_mem_addr_comb", 32'(mem_addr), 32'h1234);

    // Re-download from RUN, clean this time
    full_load("reload", 1'b0, 1'b1);
    chk("reload_run_addr", 32'(mem_addr), 32'h1234);
    chk("reload_tno", 32'(tno), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
